// File: rtl/pheap_level_ctrl_pkg.sv
// Shared types for the pipelined max-heap: heap depth, opcodes, level status,
// node entry layout and the per-level subtree capacity helper.
package pheapTypes;

   localparam int LEVELS = 4;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      ENQ  = 2'd1,
      DEQ  = 2'd2
   } opcode_t;

   typedef enum logic [1:0] {
      DONE       = 2'd0,
      BUSY       = 2'd1,
      NEXT_LEVEL = 2'd2
   } done_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EVAL = 2'd2,
      S_NEXT = 2'd3
   } state_t;

   // count = occupied nodes in the subtree rooted at this node, self included
   typedef struct packed {
      logic              active;
      logic [LEVELS-1:0] count;
      logic [31:0]       prio;
   } entry_t;

   // Nodes a subtree rooted at level k can hold; zero below the last level.
   function automatic logic [LEVELS-1:0] capacity(input int k);
      if (k > LEVELS) return '0;
      return LEVELS'((1 << (LEVELS - k + 1)) - 1);
   endfunction

endpackage

// File: rtl/pheap_level_ctrl_if.sv
// Handshake and memory-port bundle between one heap level controller and its
// surroundings (op pipeline, own node memory, child memory read port).
interface pheap_level_ctrl_if #(parameter int LEVEL = 2) ();
   import pheapTypes::*;

   localparam int PW = (LEVEL > 1) ? LEVEL - 1 : 1;

   logic             start;
   logic             shift;
   logic [PW-1:0]    pos_in;
   logic [31:0]      in;
   opcode_t          op;
   entry_t           rTop;
   entry_t           rBotL;
   entry_t           rBotR;
   logic             wenTop;
   logic             active;
   logic [PW-1:0]    raddrTop;
   logic [PW-1:0]    wraddrTop;
   logic [LEVEL-1:0] raddrBot;
   entry_t           wData;
   logic [LEVEL-1:0] endPos;
   logic [31:0]      out;
   done_t            done;

   modport master (
      output start, shift, pos_in, in, op, rTop, rBotL, rBotR,
      input  wenTop, active, raddrTop, wraddrTop, raddrBot, wData, endPos, out, done
   );

   modport slave (
      input  start, shift, pos_in, in, op, rTop, rBotL, rBotR,
      output wenTop, active, raddrTop, wraddrTop, raddrBot, wData, endPos, out, done
   );

endinterface

// File: rtl/pheap_level_ctrl_pos_reg.sv
// Start-position register: holds the node index chosen by the parent level.
module level_pos_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] pos_q;

   // Capture the parent's endPos whenever it hands the operation down.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          pos_q <= '0;
      else if (shift_i) pos_q <= d_i;
   end

   assign q_o = pos_q;

endmodule

// File: rtl/pheap_level_ctrl.sv
// One level of the pipelined max-heap: reads its node and the two children,
// applies one ENQ/DEQ step, writes the node back and hands the op downward.
// Level 1 keeps the root in a register instead of the node memory.
module pheap_level_ctrl
   import pheapTypes::*;
#(
   parameter int LEVEL = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   pheap_level_ctrl_if.slave       bus
);

   localparam int                PW   = (LEVEL > 1) ? LEVEL - 1 : 1;
   localparam logic [LEVELS-1:0] CAP  = capacity(LEVEL);
   localparam logic [LEVELS-1:0] CCAP = capacity(LEVEL + 1);

   state_t           state_q;
   done_t            done_q;
   logic             active_q;
   logic [PW-1:0]    raddrTop_q, wraddrTop_q;
   logic [LEVEL-1:0] raddrBot_q, endPos_q;
   logic [31:0]      out_q, in_q;
   opcode_t          op_q;
   entry_t           root_q;

   logic [PW-1:0]    pos_q, pos_nxt, naddr;
   logic [LEVEL-1:0] child_base;

   level_pos_reg #(.W(PW)) u_pos (
      .clk     (clk),
      .rst     (rst),
      .shift_i (bus.shift),
      .d_i     (bus.pos_in),
      .q_o     (pos_q)
   );

   // pos_in arrives on the same edge as start, so bypass the register then
   assign pos_nxt = bus.shift ? bus.pos_in : pos_q;
   assign naddr   = (LEVEL == 1) ? '0 : pos_nxt;

   if (LEVEL == 1) begin : g_root_base
      assign child_base = '0;
   end else begin : g_node_base
      assign child_base = {pos_nxt, 1'b0};
   end

   entry_t      node, lc, rc, child, wdat_d;
   logic        wen_d, sel_d, go_next, pick_r;
   logic [31:0] out_d;

   // EVAL decision: node and child data from the synchronous read are valid now.
   always_comb begin
      node    = (LEVEL == 1) ? root_q : bus.rTop;
      lc      = bus.rBotL;
      rc      = bus.rBotR;
      wen_d   = 1'b0;
      wdat_d  = '0;
      out_d   = out_q;
      sel_d   = 1'b0;
      go_next = 1'b0;
      pick_r  = 1'b0;
      child   = lc;
      case (op_q)
         ENQ: begin
            if (!node.active) begin
               wen_d  = 1'b1;
               wdat_d = '{active: 1'b1, count: LEVELS'(1), prio: in_q};
               out_d  = '0;
            end else if (node.count == CAP) begin
               out_d  = '0;   // subtree full: drop the value
            end else begin
               wen_d        = 1'b1;
               wdat_d.active = 1'b1;
               wdat_d.count  = node.count + LEVELS'(1);
               // ties keep the stored value and push the newcomer down
               if (in_q > node.prio) begin
                  wdat_d.prio = in_q;
                  out_d       = node.prio;
               end else begin
                  wdat_d.prio = node.prio;
                  out_d       = in_q;
               end
               sel_d   = !(lc.count < CCAP);
               go_next = 1'b1;
            end
         end
         DEQ: begin
            if (!node.active) begin
               out_d = '0;
            end else begin
               out_d = node.prio;
               wen_d = 1'b1;
               if (!lc.active && !rc.active) begin
                  wdat_d = '0;
               end else begin
                  // larger active child moves up; equal priorities favour left
                  pick_r = !lc.active || (rc.active && (rc.prio > lc.prio));
                  child  = pick_r ? rc : lc;
                  wdat_d = '{active: 1'b1, count: node.count - LEVELS'(1), prio: child.prio};
                  sel_d   = pick_r;
                  go_next = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Operation sequencer: IDLE -> READ -> EVAL -> (NEXT_LEVEL) -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         done_q      <= DONE;
         active_q    <= 1'b0;
         raddrTop_q  <= '0;
         wraddrTop_q <= '0;
         raddrBot_q  <= '0;
         endPos_q    <= '0;
         out_q       <= '0;
         in_q        <= '0;
         op_q        <= FREE;
         root_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start && bus.op != FREE) begin
                  state_q     <= S_READ;
                  done_q      <= BUSY;
                  active_q    <= 1'b1;
                  op_q        <= bus.op;
                  in_q        <= bus.in;
                  raddrTop_q  <= naddr;
                  wraddrTop_q <= naddr;
                  raddrBot_q  <= child_base;
               end
            end
            S_READ: begin
               state_q  <= S_EVAL;
               active_q <= 1'b0;
            end
            S_EVAL: begin
               out_q <= out_d;
               if (LEVEL == 1 && wen_d) root_q <= wdat_d;
               if (go_next) begin
                  endPos_q <= raddrBot_q | LEVEL'(sel_d);
                  state_q  <= S_NEXT;
                  done_q   <= NEXT_LEVEL;
               end else begin
                  state_q  <= S_IDLE;
                  done_q   <= DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= DONE;
            end
         endcase
      end
   end

   assign bus.wenTop    = (LEVEL > 1) && (state_q == S_EVAL) && wen_d;
   assign bus.wData     = ((LEVEL > 1) && (state_q == S_EVAL)) ? wdat_d : '0;
   assign bus.active    = active_q;
   assign bus.raddrTop  = raddrTop_q;
   assign bus.wraddrTop = wraddrTop_q;
   assign bus.raddrBot  = raddrBot_q;
   assign bus.endPos    = endPos_q;
   assign bus.out       = out_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_pheap_level_ctrl.sv
// Directed bench for the heap level controller: a level-1 (root register)
// instance and a level-2 (node memory) instance driven step by step.
module tb_pheap_level_ctrl;
   import pheapTypes::*;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   pheap_level_ctrl_if #(.LEVEL(1)) b1 ();
   pheap_level_ctrl_if #(.LEVEL(2)) b2 ();

   pheap_level_ctrl #(.LEVEL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   pheap_level_ctrl #(.LEVEL(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

   function automatic entry_t E(input bit a, input int c, input int p);
      entry_t e;
      e.active = a;
      e.count  = LEVELS'(c);
      e.prio   = 32'(p);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run1(input opcode_t o, input int v);
      b1.op = o; b1.in = 32'(v); b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      tick();
      tick();
   endtask

   task automatic start2(input opcode_t o, input int v, input bit sh, input int p, input entry_t top);
      b2.op = o; b2.in = 32'(v); b2.shift = sh; b2.pos_in = 1'(p); b2.rTop = top;
      b2.start = 1'b1;
      tick();
      b2.start = 1'b0; b2.shift = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      b1.start = 0; b1.shift = 0; b1.pos_in = '0; b1.in = '0; b1.op = FREE;
      b1.rTop = '0; b1.rBotL = '0; b1.rBotR = '0;
      b2.start = 0; b2.shift = 0; b2.pos_in = '0; b2.in = '0; b2.op = FREE;
      b2.rTop = '0; b2.rBotL = '0; b2.rBotR = '0;
      tick();
      tick();
      chk("rst_done",   b2.done, DONE);
      chk("rst_wen",    b2.wenTop, 0);
      chk("rst_active", b2.active, 0);
      chk("rst_out",    b2.out, 0);
      chk("rst_raddr",  b2.raddrTop, 0);
      chk("rst_pos",    dut2.pos_q, 0);
      chk("rst_root",   dut1.root_q, 0);
      rst = 1'b0;
      tick();

      // level 1: ENQ 5 into empty root
      b1.op = ENQ; b1.in = 5; b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      chk("l1_read_busy",   b1.done, BUSY);
      chk("l1_read_active", b1.active, 1);
      tick();
      chk("l1_eval_wen0",   b1.wenTop, 0);
      tick();
      chk("l1_enq5_done",   b1.done, DONE);
      chk("l1_enq5_root",   dut1.root_q, E(1, 1, 5));

      // level 1: ENQ 9 displaces 5
      run1(ENQ, 9);
      chk("l1_enq9_done",   b1.done, NEXT_LEVEL);
      chk("l1_enq9_root",   dut1.root_q, E(1, 2, 9));
      chk("l1_enq9_out",    b1.out, 5);
      chk("l1_enq9_endpos", b1.endPos, 0);
      tick();
      chk("l1_enq9_back",   b1.done, DONE);

      // level 1: ENQ 1 passes down, root count 3
      run1(ENQ, 1);
      chk("l1_enq1_out",    b1.out, 1);
      chk("l1_enq1_root",   dut1.root_q, E(1, 3, 9));
      tick();

      // level 1: DEQ picks larger child (right, 8)
      b1.rBotL = E(1, 1, 5); b1.rBotR = E(1, 1, 8);
      run1(DEQ, 0);
      chk("l1_deq_out",     b1.out, 9);
      chk("l1_deq_root",    dut1.root_q, E(1, 2, 8));
      chk("l1_deq_endpos",  b1.endPos, 1);
      chk("l1_deq_done",    b1.done, NEXT_LEVEL);
      tick();

      // level 1: DEQ with no children empties the root
      b1.rBotL = '0; b1.rBotR = '0;
      run1(DEQ, 0);
      chk("l1_deq_last_out",  b1.out, 8);
      chk("l1_deq_last_root", dut1.root_q, 0);
      chk("l1_deq_last_done", b1.done, DONE);

      // level 1: DEQ on empty heap
      run1(DEQ, 0);
      chk("l1_deq_empty_out",  b1.out, 0);
      chk("l1_deq_empty_done", b1.done, DONE);
      chk("l1_deq_empty_root", dut1.root_q, 0);

      // level 2: ENQ at position 1, left child has room
      start2(ENQ, 3, 1, 1, E(1, 1, 7));
      chk("l2_raddrTop",    b2.raddrTop, 1);
      chk("l2_raddrBot",    b2.raddrBot, 2);
      chk("l2_active",      b2.active, 1);
      tick();
      chk("l2_enq_wen",     b2.wenTop, 1);
      chk("l2_enq_wdata",   b2.wData, E(1, 2, 7));
      chk("l2_enq_wraddr",  b2.wraddrTop, 1);
      tick();
      chk("l2_enq_out",     b2.out, 3);
      chk("l2_enq_endpos",  b2.endPos, 2);
      chk("l2_enq_done",    b2.done, NEXT_LEVEL);
      tick();

      // level 2: ENQ larger value, left child full -> right
      b2.rBotL = E(1, 3, 4);
      start2(ENQ, 10, 1, 0, E(1, 4, 7));
      tick();
      chk("l2_enq2_wdata",  b2.wData, E(1, 5, 10));
      tick();
      chk("l2_enq2_out",    b2.out, 7);
      chk("l2_enq2_endpos", b2.endPos, 1);
      tick();

      // level 2: DEQ with equal children takes left
      b2.rBotL = E(1, 1, 6); b2.rBotR = E(1, 1, 6);
      start2(DEQ, 0, 0, 0, E(1, 3, 9));
      tick();
      chk("l2_deq_wdata",   b2.wData, E(1, 2, 6));
      tick();
      chk("l2_deq_out",     b2.out, 9);
      chk("l2_deq_endpos",  b2.endPos, 0);
      chk("l2_deq_done",    b2.done, NEXT_LEVEL);
      tick();

      // level 2: ENQ into full subtree is dropped
      b2.rBotL = '0; b2.rBotR = '0;
      start2(ENQ, 30, 0, 0, E(1, 7, 20));
      tick();
      chk("l2_full_wen",    b2.wenTop, 0);
      tick();
      chk("l2_full_done",   b2.done, DONE);

      // level 2: DEQ on empty node
      start2(DEQ, 0, 0, 0, E(0, 0, 0));
      tick();
      chk("l2_empty_wen",   b2.wenTop, 0);
      tick();
      chk("l2_empty_out",   b2.out, 0);
      chk("l2_empty_done",  b2.done, DONE);

      // FREE start is ignored
      start2(FREE, 0, 0, 0, E(1, 1, 1));
      chk("l2_free_done",   b2.done, DONE);
      chk("l2_free_active", b2.active, 0);

      // reset during READ aborts immediately
      start2(ENQ, 3, 1, 1, E(1, 1, 7));
      chk("l2_pre_rst_pos",  dut2.pos_q, 1);
      chk("l2_pre_rst_busy", b2.done, BUSY);
      rst = 1'b1;
      #1;
      chk("l2_rst_done",    b2.done, DONE);
      chk("l2_rst_wen",     b2.wenTop, 0);
      chk("l2_rst_active",  b2.active, 0);
      chk("l2_rst_pos",     dut2.pos_q, 0);
      chk("l2_rst_raddr",   b2.raddrTop, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("l2_post_rst_done", b2.done, DONE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
